// File: rtl/spi_prog_loader.sv
// spi_prog_loader: SPI mode-0 slave that turns the pre-boot programming
// byte stream (0x01 + 4 address bytes, 0x02 + 4 data bytes, MSB first)
// into 32-bit memory write requests with a valid/ready handshake.
module spi_prog_loader #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ADDR_INC    = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [2:0]  status
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_WR} state_t;

    localparam logic [7:0] CMD_ADDR = 8'h01;
    localparam logic [7:0] CMD_DATA = 8'h02;

    // Pad synchronizers; cs_n idles high so its chain resets to all ones.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic cs_prev_q, cs_prev_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise;

    // Bit engine
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] tx_sh_q, tx_sh_d;

    // Protocol state
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_valid_q, wr_valid_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        overflow_q, overflow_d;
    logic        bad_cmd_q, bad_cmd_d;

    logic        accept, pend, busy;
    logic [31:0] addr_base;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    assign busy     = (state_q != IDLE) || wr_valid_q;
    assign status   = {overflow_q, bad_cmd_q, busy};
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign miso     = ~cs_s & tx_sh_q[7];

    // Synchronizer shift and edge-detect history.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    // Shift MOSI on rising sclk, flag each completed byte; MISO shifts on falling sclk.
    always_comb begin
        bitcnt_d    = bitcnt_q;
        rx_sh_d     = rx_sh_q;
        byte_done_d = 1'b0;
        tx_sh_d     = tx_sh_q;
        if (cs_rise) begin
            bitcnt_d = 3'd0;
        end else if (!cs_s && sclk_rise) begin
            rx_sh_d = {rx_sh_q[6:0], mosi_s};
            if (bitcnt_q == 3'd7) begin
                bitcnt_d    = 3'd0;
                byte_done_d = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + 3'd1;
            end
        end
        // Reload status at each byte boundary; the load wins over the
        // trailing falling edge of the previous byte.
        if (!cs_s && bitcnt_q == 3'd0 && !sclk_rise) begin
            tx_sh_d = {5'b0, status};
        end else if (!cs_s && sclk_fall) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
    end

    // Command decode, field assembly and write handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q;
        bad_cmd_d  = bad_cmd_q;

        // Acceptance is resolved before any byte in the same cycle.
        accept     = wr_valid_q && wr_ready;
        pend       = wr_valid_q && !wr_ready;
        addr_base  = accept ? addr_q + ADDR_INC : addr_q;
        addr_d     = addr_base;
        wr_valid_d = pend;
        if (accept && state_q == WAIT_WR) state_d = IDLE;

        if (byte_done_q) begin
            case (state_q)
                ADDR: begin
                    addr_d = {addr_base[23:0], rx_sh_q};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = pend ? WAIT_WR : IDLE;
                end
                DATA: begin
                    data_d = {data_q[23:0], rx_sh_q};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = WAIT_WR;
                        if (pend) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_addr_d  = addr_base;
                            wr_data_d  = {data_q[23:0], rx_sh_q};
                            wr_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and WAIT_WR both decode commands.
                    if (rx_sh_q == CMD_ADDR) begin
                        state_d = ADDR;
                        cnt_d   = 2'd0;
                    end else if (rx_sh_q == CMD_DATA) begin
                        state_d = DATA;
                        cnt_d   = 2'd0;
                    end else begin
                        bad_cmd_d = 1'b1;
                    end
                end
            endcase
        end

        // Deselect abandons a partial field but keeps any pending write.
        if (cs_rise && (state_d == ADDR || state_d == DATA))
            state_d = wr_valid_d ? WAIT_WR : IDLE;
    end

    // Register update for all state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bitcnt_q    <= 3'd0;
            rx_sh_q     <= 8'd0;
            byte_done_q <= 1'b0;
            tx_sh_q     <= 8'd0;
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 32'd0;
            wr_data_q   <= 32'd0;
            overflow_q  <= 1'b0;
            bad_cmd_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bitcnt_q    <= bitcnt_d;
            rx_sh_q     <= rx_sh_d;
            byte_done_q <= byte_done_d;
            tx_sh_q     <= tx_sh_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            overflow_q  <= overflow_d;
            bad_cmd_q   <= bad_cmd_d;
        end
    end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Directed bench for spi_prog_loader: drives SPI frames, records every
// accepted write and checks addresses, data, latency and status flags.
module tb_spi_prog_loader;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  status;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int rise_cyc = 0;
    int vld_cycles = 0;
    logic vld_prev = 1'b0;
    logic [31:0] acc_addr[$];
    logic [31:0] acc_data[$];

    spi_prog_loader #(.SYNC_STAGES(2), .ADDR_INC(32'd4)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .status(status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_valid && !vld_prev) rise_cyc = cyc;
        if (wr_valid) vld_cycles = vld_cycles + 1;
        if (wr_valid && wr_ready) begin
            acc_addr.push_back(wr_addr);
            acc_data.push_back(wr_data);
        end
        vld_prev = wr_valid;
    end

    task automatic clear_log();
        acc_addr.delete();
        acc_data.delete();
        vld_cycles = 0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 wr_ready = r;
    endtask

    task automatic spi_begin();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            last_rise_cyc = cyc;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] val);
        spi_byte(cmd);
        spi_byte(val[31:24]);
        spi_byte(val[23:16]);
        spi_byte(val[15:8]);
        spi_byte(val[7:0]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        tests_run++; if (wr_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        tests_run++; if (wr_data !== 32'h0) begin tests_failed++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        tests_run++; if (status !== 3'b000) begin tests_failed++; $display("FAIL reset_status: got %b want 000", status); end
        tests_run++; if (miso !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b want 0", miso); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_write();
        clear_log();
        spi_begin();
        send_cmd(8'h01, 32'h1000_0000);
        send_cmd(8'h02, 32'hDEAD_BEEF);
        spi_end();
        tests_run++; if (acc_addr.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", acc_addr.size()); end
        if (acc_addr.size() > 0) begin
            tests_run++; if (acc_addr[0] !== 32'h1000_0000) begin tests_failed++; $display("FAIL single_addr: got %h want 10000000", acc_addr[0]); end
            tests_run++; if (acc_data[0] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL single_data: got %h want deadbeef", acc_data[0]); end
        end
        tests_run++; if (rise_cyc - last_rise_cyc != 4) begin tests_failed++; $display("FAIL single_latency: got %0d want 4", rise_cyc - last_rise_cyc); end
        tests_run++; if (vld_cycles != 1) begin tests_failed++; $display("FAIL single_pulse: got %0d want 1", vld_cycles); end
        tests_run++; if (status !== 3'b000) begin tests_failed++; $display("FAIL single_status: got %b want 000", status); end
    endtask

    task automatic test_seq_addr();
        logic [31:0] exp_a[3];
        logic [31:0] exp_d[3];
        exp_a = '{32'h1000_4000, 32'h1000_4004, 32'h1000_4008};
        exp_d = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        clear_log();
        spi_begin();
        send_cmd(8'h01, 32'h1000_4000);
        for (int i = 0; i < 3; i++) send_cmd(8'h02, exp_d[i]);
        spi_end();
        tests_run++; if (acc_addr.size() != 3) begin tests_failed++; $display("FAIL seq_count: got %0d want 3", acc_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            if (acc_addr.size() > i) begin
                tests_run++; if (acc_addr[i] !== exp_a[i] || acc_data[i] !== exp_d[i]) begin
                    tests_failed++;
                    $display("FAIL seq_write%0d: got %h/%h want %h/%h", i, acc_addr[i], acc_data[i], exp_a[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        clear_log();
        set_ready(1'b0);
        spi_begin();
        send_cmd(8'h02, 32'hCAFE_0001);
        repeat (8) @(negedge clk);
        tests_run++; if (wr_valid !== 1'b1 || wr_addr !== 32'h1000_400C || wr_data !== 32'hCAFE_0001) begin
            tests_failed++; $display("FAIL ovf_first_held: got v=%b %h/%h want 1 1000400c/cafe0001", wr_valid, wr_addr, wr_data);
        end
        send_cmd(8'h02, 32'h0000_0099);
        spi_end();
        tests_run++; if (status !== 3'b101) begin tests_failed++; $display("FAIL ovf_status: got %b want 101", status); end
        tests_run++; if (wr_valid !== 1'b1 || wr_data !== 32'hCAFE_0001) begin
            tests_failed++; $display("FAIL ovf_kept: got v=%b %h want 1 cafe0001", wr_valid, wr_data);
        end
        set_ready(1'b1);
        repeat (6) @(negedge clk);
        tests_run++; if (acc_data.size() != 1) begin tests_failed++; $display("FAIL ovf_count: got %0d want 1", acc_data.size()); end
        if (acc_data.size() > 0) begin
            tests_run++; if (acc_data[0] !== 32'hCAFE_0001 || acc_addr[0] !== 32'h1000_400C) begin
                tests_failed++; $display("FAIL ovf_write: got %h/%h want 1000400c/cafe0001", acc_addr[0], acc_data[0]);
            end
        end
        tests_run++; if (status !== 3'b100) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 100", status); end
    endtask

    task automatic test_bad_cmd();
        clear_log();
        spi_begin();
        spi_byte(8'h55);
        spi_end();
        tests_run++; if (status !== 3'b110) begin tests_failed++; $display("FAIL bad_status: got %b want 110", status); end
        tests_run++; if (acc_addr.size() != 0) begin tests_failed++; $display("FAIL bad_nowrite: got %0d want 0", acc_addr.size()); end
        spi_begin();
        send_cmd(8'h01, 32'h2000_0000);
        send_cmd(8'h02, 32'h0000_0001);
        spi_end();
        tests_run++; if (acc_addr.size() != 1) begin tests_failed++; $display("FAIL bad_then_count: got %0d want 1", acc_addr.size()); end
        if (acc_addr.size() > 0) begin
            tests_run++; if (acc_addr[0] !== 32'h2000_0000 || acc_data[0] !== 32'h0000_0001) begin
                tests_failed++; $display("FAIL bad_then_write: got %h/%h want 20000000/00000001", acc_addr[0], acc_data[0]);
            end
        end
    endtask

    task automatic test_cs_abort();
        clear_log();
        spi_begin();
        spi_byte(8'h02);
        spi_byte(8'hAA);
        spi_byte(8'hBB);
        spi_end();
        tests_run++; if (acc_addr.size() != 0 || status[0] !== 1'b0) begin
            tests_failed++; $display("FAIL abort_partial: got %0d writes busy=%b want 0/0", acc_addr.size(), status[0]);
        end
        spi_begin();
        send_cmd(8'h02, 32'h1122_3344);
        spi_end();
        tests_run++; if (acc_addr.size() != 1) begin tests_failed++; $display("FAIL abort_count: got %0d want 1", acc_addr.size()); end
        if (acc_addr.size() > 0) begin
            tests_run++; if (acc_addr[0] !== 32'h2000_0004 || acc_data[0] !== 32'h1122_3344) begin
                tests_failed++; $display("FAIL abort_write: got %h/%h want 20000004/11223344", acc_addr[0], acc_data[0]);
            end
        end
    endtask

    task automatic test_wrap();
        clear_log();
        spi_begin();
        send_cmd(8'h01, 32'hFFFF_FFFC);
        send_cmd(8'h02, 32'h0BAD_F00D);
        send_cmd(8'h02, 32'h600D_CAFE);
        spi_end();
        tests_run++; if (acc_addr.size() != 2) begin tests_failed++; $display("FAIL wrap_count: got %0d want 2", acc_addr.size()); end
        if (acc_addr.size() > 1) begin
            tests_run++; if (acc_addr[0] !== 32'hFFFF_FFFC || acc_addr[1] !== 32'h0000_0000) begin
                tests_failed++; $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", acc_addr[0], acc_addr[1]);
            end
            tests_run++; if (acc_data[1] !== 32'h600D_CAFE) begin tests_failed++; $display("FAIL wrap_data: got %h want 600dcafe", acc_data[1]); end
        end
    endtask

    task automatic test_async_reset();
        set_ready(1'b0);
        spi_begin();
        send_cmd(8'h02, 32'h1234_5678);
        spi_byte(8'h01);
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (8) @(negedge clk);
        tests_run++; if (wr_valid !== 1'b1 || wr_data !== 32'h1234_5678 || wr_addr !== 32'h0000_0004) begin
            tests_failed++; $display("FAIL areset_pre: got v=%b %h/%h want 1 00000004/12345678", wr_valid, wr_addr, wr_data);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run++; if (wr_valid !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0 || status !== 3'b000 || miso !== 1'b0) begin
            tests_failed++; $display("FAIL areset_outputs: got v=%b a=%h d=%h s=%b m=%b want all 0", wr_valid, wr_addr, wr_data, status, miso);
        end
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        wr_ready = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        // Address register was cleared by reset, so the next word lands at 0.
        clear_log();
        spi_begin();
        send_cmd(8'h02, 32'hA5A5_A5A5);
        spi_end();
        tests_run++; if (acc_addr.size() != 1) begin tests_failed++; $display("FAIL areset_after_count: got %0d want 1", acc_addr.size()); end
        if (acc_addr.size() > 0) begin
            tests_run++; if (acc_addr[0] !== 32'h0 || acc_data[0] !== 32'hA5A5_A5A5) begin
                tests_failed++; $display("FAIL areset_after_write: got %h/%h want 00000000/a5a5a5a5", acc_addr[0], acc_data[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_seq_addr();
        test_overflow();
        test_bad_cmd();
        test_cs_abort();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
